// File: rtl/bill_front_end.sv
// Input front end for the vending FSM: validates bill pulses by width, debounces the
// two buttons and arbitrates everything into clean single-cycle pulses.

module btn_debounce #(
   parameter int DEB = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);
   localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

   logic [1:0]    sync;
   logic          level;
   logic [DW-1:0] cnt;

   // NOTE: non-blocking assignments let sync[1] pick up the old sync[0], giving a true two-stage chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == DW'(DEB - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            rise  <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module bill_front_end #(
   parameter int MIN_W = 4,
   parameter int MAX_W = 16,
   parameter int DEB   = 3,
   parameter int CNT_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bill_sense,
   input  logic       btn_purchase,
   input  logic       btn_cancel,
   input  logic       accept_en,
   output logic       insert_bill,
   output logic       purchase,
   output logic       cancel,
   output logic       reject,
   output logic       jam,
   output logic [7:0] bill_count
);
   typedef enum logic [1:0] {
      B_IDLE,
      B_MEASURE,
      B_JAM
   } bill_state_t;

   bill_state_t      state;
   logic [1:0]       bill_sync;
   logic [CNT_W-1:0] w;
   logic             s;
   logic             rise_p, rise_c;
   logic             pend_p, pend_c;
   logic             want_p, want_c;
   logic             bill_accept;

   btn_debounce #(.DEB(DEB)) u_deb_purchase (
      .clk (clk),
      .rst (rst),
      .raw (btn_purchase),
      .rise(rise_p)
   );

   btn_debounce #(.DEB(DEB)) u_deb_cancel (
      .clk (clk),
      .rst (rst),
      .raw (btn_cancel),
      .rise(rise_c)
   );

   assign s = bill_sync[1];

   // A bill is judged in the first cycle the synchronised sense is seen low.
   assign bill_accept = (state == B_MEASURE) && !s && (w >= CNT_W'(MIN_W)) && accept_en;

   assign want_c = rise_c | pend_c;
   assign want_p = rise_p | pend_p;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bill_sync   <= '0;
         state       <= B_IDLE;
         w           <= '0;
         jam         <= 1'b0;
         reject      <= 1'b0;
         insert_bill <= 1'b0;
         bill_count  <= '0;
         purchase    <= 1'b0;
         cancel      <= 1'b0;
         pend_p      <= 1'b0;
         pend_c      <= 1'b0;
      end else begin
         bill_sync   <= {bill_sync[0], bill_sense};
         reject      <= 1'b0;
         insert_bill <= bill_accept;

         case (state)
            B_IDLE: begin
               if (s) begin
                  state <= B_MEASURE;
                  w     <= CNT_W'(1);
               end
            end
            B_MEASURE: begin
               if (s) begin
                  if (w >= CNT_W'(MAX_W)) begin
                     state <= B_JAM;
                     jam   <= 1'b1;
                  end else begin
                     w <= w + 1'b1;
                  end
               end else begin
                  state <= B_IDLE;
                  w     <= '0;
                  if (w >= CNT_W'(MIN_W) && !accept_en) reject <= 1'b1;
               end
            end
            B_JAM: begin
               if (!s) begin
                  state  <= B_IDLE;
                  w      <= '0;
                  jam    <= 1'b0;
                  reject <= 1'b1;
               end
            end
            default: begin
               state <= B_IDLE;
               w     <= '0;
               jam   <= 1'b0;
            end
         endcase

         if (bill_accept && bill_count != 8'hFF) bill_count <= bill_count + 1'b1;

         // Commands yield to a bill pulse for one cycle; cancel always beats purchase.
         if (bill_accept) begin
            purchase <= 1'b0;
            cancel   <= 1'b0;
            pend_c   <= want_c;
            pend_p   <= want_p & ~want_c;
         end else begin
            cancel   <= want_c;
            purchase <= want_p & ~want_c;
            pend_c   <= 1'b0;
            pend_p   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bill_front_end.sv
// Self-checking bench for bill_front_end: directed and random scenarios compared each
// cycle against an event schedule derived from raw-edge timing rules.

module tb_bill_front_end;
   localparam int MIN_W = 4;
   localparam int MAX_W = 16;
   localparam int DEB   = 3;
   localparam int NC    = 16384;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bill_sense = 1'b0;
   logic       btn_purchase = 1'b0;
   logic       btn_cancel = 1'b0;
   logic       accept_en = 1'b0;
   logic       insert_bill, purchase, cancel, reject, jam;
   logic [7:0] bill_count;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Expected events per clock edge: bill outcomes, jam level, raw command requests.
   bit e_ins [NC];
   bit e_rej [NC];
   bit e_jam [NC];
   bit r_pur [NC];
   bit r_can [NC];

   int m_count  = 0;
   bit m_pend_p = 1'b0;
   bit m_pend_c = 1'b0;

   bill_front_end #(.MIN_W(MIN_W), .MAX_W(MAX_W), .DEB(DEB), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .bill_sense  (bill_sense),
      .btn_purchase(btn_purchase),
      .btn_cancel  (btn_cancel),
      .accept_en   (accept_en),
      .insert_bill (insert_bill),
      .purchase    (purchase),
      .cancel      (cancel),
      .reject      (reject),
      .jam         (jam),
      .bill_count  (bill_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " insert_bill"}, 8'(insert_bill), 8'd0);
      check({tag, " purchase"},    8'(purchase),    8'd0);
      check({tag, " cancel"},      8'(cancel),      8'd0);
      check({tag, " reject"},      8'(reject),      8'd0);
      check({tag, " jam"},         8'(jam),         8'd0);
      check({tag, " bill_count"},  bill_count,      8'd0);
   endtask

   // One clock edge, then compare every output with the schedule.
   task automatic tick();
      bit want_c, want_p, exp_ins, exp_c, exp_p;
      @(posedge clk);
      #1;
      cyc++;
      exp_ins = e_ins[cyc];
      want_c  = r_can[cyc] | m_pend_c;
      want_p  = r_pur[cyc] | m_pend_p;
      if (exp_ins) begin
         exp_c    = 1'b0;
         exp_p    = 1'b0;
         m_pend_c = want_c;
         m_pend_p = want_p && !want_c;
         if (m_count < 255) m_count++;
      end else begin
         exp_c    = want_c;
         exp_p    = want_p && !want_c;
         m_pend_c = 1'b0;
         m_pend_p = 1'b0;
      end
      check("insert_bill", 8'(insert_bill), 8'(exp_ins));
      check("reject",      8'(reject),      8'(e_rej[cyc]));
      check("jam",         8'(jam),         8'(e_jam[cyc]));
      check("cancel",      8'(cancel),      8'(exp_c));
      check("purchase",    8'(purchase),    8'(exp_p));
      check("bill_count",  bill_count,      8'(m_count));
   endtask

   // Offset from press start to the first edge of the final stable-high run.
   function automatic int stable_off(input int bnc);
      if (bnc < 2) return 0;
      return (bnc % 2 == 0) ? bnc : bnc - 1;
   endfunction

   // Bouncy press: alternates 1,0,1,... for bnc cycles, then held high until on+len.
   function automatic logic btn_level(input int k, input int on, input int len, input int bnc);
      if (on < 0 || k < on || k >= on + len) return 1'b0;
      if (k - on < bnc) return ((k - on) % 2 == 0);
      return 1'b1;
   endfunction

   task automatic scenario(input int b_on, input int b_len, input bit acc,
                           input int p_on, input int p_len, input int p_bnc,
                           input int c_on, input int c_len, input int c_bnc,
                           input int total);
      int e0, fall, j;
      e0 = cyc + 1;
      if (e0 + total + 8 >= NC) begin
         $display("FAIL cycle_budget: cycle %0d plus %0d exceeds limit %0d", cyc, total, NC);
         $fatal(1, "schedule overflow");
      end
      accept_en = acc;
      if (b_on >= 0) begin
         fall = e0 + b_on + b_len;
         j    = fall + 2;
         if (b_len > MAX_W) begin
            for (int k = e0 + b_on + MAX_W + 2; k <= fall + 1; k++) e_jam[k] = 1'b1;
            e_rej[j] = 1'b1;
         end else if (b_len >= MIN_W) begin
            if (acc) e_ins[j] = 1'b1;
            else     e_rej[j] = 1'b1;
         end
      end
      if (p_on >= 0) r_pur[e0 + p_on + stable_off(p_bnc) + DEB + 2] = 1'b1;
      if (c_on >= 0) r_can[e0 + c_on + stable_off(c_bnc) + DEB + 2] = 1'b1;
      for (int k = 0; k < total; k++) begin
         bill_sense   = (b_on >= 0) && (k >= b_on) && (k < b_on + b_len);
         btn_purchase = btn_level(k, p_on, p_len, p_bnc);
         btn_cancel   = btn_level(k, c_on, c_len, c_bnc);
         tick();
      end
      bill_sense   = 1'b0;
      btn_purchase = 1'b0;
      btn_cancel   = 1'b0;
   endtask

   // Assert reset between edges, check the outputs clear at once, hold, release mid-cycle.
   task automatic do_reset(input string tag, input int hold);
      #2 rst = 1'b0;
      #1;
      for (int k = cyc + 1; k < NC; k++) begin
         e_ins[k] = 1'b0;
         e_rej[k] = 1'b0;
         e_jam[k] = 1'b0;
         r_pur[k] = 1'b0;
         r_can[k] = 1'b0;
      end
      m_count  = 0;
      m_pend_p = 1'b0;
      m_pend_c = 1'b0;
      check_all_zero(tag);
      repeat (hold) tick();
      #2 rst = 1'b1;
   endtask

   initial begin
      int b_on, b_len, p_on, p_len, p_bnc, c_on, c_len, c_bnc, total, e;
      bit acc;

      #1 rst = 1'b0;
      #1 check_all_zero("reset_values");
      tick();
      tick();
      #2 rst = 1'b1;

      // Valid bill, glitch, gated bill.
      scenario(0, 8, 1'b1, -1, 0, 0, -1, 0, 0, 14);
      scenario(0, 2, 1'b1, -1, 0, 0, -1, 0, 0, 10);
      scenario(0, 8, 1'b0, -1, 0, 0, -1, 0, 0, 14);

      // Width boundaries.
      scenario(0, MIN_W - 1, 1'b1, -1, 0, 0, -1, 0, 0, 12);
      scenario(0, MIN_W,     1'b1, -1, 0, 0, -1, 0, 0, 12);
      scenario(0, MAX_W,     1'b1, -1, 0, 0, -1, 0, 0, 24);
      scenario(0, MAX_W + 1, 1'b1, -1, 0, 0, -1, 0, 0, 26);

      // Long jam.
      scenario(0, 30, 1'b1, -1, 0, 0, -1, 0, 0, 36);

      // Bouncy purchase press then clean release.
      scenario(-1, 0, 1'b1, 0, 20, 10, -1, 0, 0, 32);

      // Collisions: command pulse coincides with insert_bill; cancel beats purchase.
      scenario(0, 8, 1'b1, 5, 10, 0, -1, 0, 0, 25);
      scenario(0, 8, 1'b1, 5, 10, 0, 5, 10, 0, 25);
      scenario(-1, 0, 1'b1, 0, 8, 0, 0, 8, 0, 18);
      scenario(-1, 0, 1'b1, -1, 0, 0, 2, 9, 3, 20);

      // Reset in the middle of a jam, sense still high at release.
      accept_en  = 1'b1;
      e          = cyc + 1;
      for (int k = e + MAX_W + 2; k <= e + 21; k++) e_jam[k] = 1'b1;
      bill_sense = 1'b1;
      repeat (22) tick();
      do_reset("reset_mid_jam", 3);
      scenario(0, 6, 1'b1, -1, 0, 0, -1, 0, 0, 12);

      // Reset mid-measure with the bill gone by release: nothing may come out.
      bill_sense = 1'b1;
      repeat (6) tick();
      bill_sense = 1'b0;
      do_reset("reset_mid_measure", 2);
      scenario(-1, 0, 1'b1, -1, 0, 0, -1, 0, 0, 10);

      // Random mix of bills and presses.
      for (int i = 0; i < 60; i++) begin
         b_on  = int'($urandom_range(0, 3));
         b_len = int'($urandom_range(1, 24));
         if ($urandom_range(0, 4) == 0) b_on = -1;
         acc   = 1'($urandom_range(0, 1));
         p_on  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
         p_bnc = int'($urandom_range(0, 6));
         p_len = p_bnc + int'($urandom_range(4, 8));
         c_on  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
         c_bnc = int'($urandom_range(0, 6));
         c_len = c_bnc + int'($urandom_range(4, 8));
         total = 6;
         if (b_on >= 0 && b_on + b_len + 4 > total) total = b_on + b_len + 4;
         if (p_on >= 0 && p_on + p_len + 8 > total) total = p_on + p_len + 8;
         if (c_on >= 0 && c_on + c_len + 8 > total) total = c_on + c_len + 8;
         scenario(b_on, b_len, acc, p_on, p_len, p_bnc, c_on, c_len, c_bnc, total);
      end

      // Saturation of the accepted-bill counter.
      for (int i = 0; i < 260; i++) scenario(0, MIN_W, 1'b1, -1, 0, 0, -1, 0, 0, MIN_W + 4);
      check("bill_count_saturated", bill_count, 8'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
